// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter
// Purpose  : 31-entry register file ($zero hard-wired to 0) shared by two
//            requesters over a four-phase req/ack handshake. A round-robin
//            arbiter picks one requester per transaction. Its command is
//            latched in IDLE, executed in SERVE and acknowledged in DONE.
//            ack stays high until the served requester drops its req.
// Ports    : clk            - single clock, rising edge
//            reset          - synchronous, active-high
//            req0/req1      - access request per port
//            we0/we1        - 1 = write, 0 = read
//            addr0/addr1    - register index (0 = $zero)
//            wdata0/wdata1  - write data
//            ack0/ack1      - access complete (four-phase)
//            rdata0/rdata1  - last read result for that port
//            busy           - FSM not in IDLE
//            grant          - port being served (valid while busy)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [4:0]            addr0,
    input  logic [4:0]            addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_regs [1:31];
    logic                    r_grant;
    logic                    r_last;     // port served by the previous transaction
    logic                    r_we;
    logic [4:0]              r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_ack0;
    logic                    r_ack1;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;

    logic                    w_any_req;
    logic                    w_winner;
    logic                    w_req_granted;
    logic [DATA_WIDTH-1:0]   w_rd_value;

    assign w_any_req = req0 | req1;

    // A lone request wins outright. On a tie, the port not served last wins.
    // r_last resets to 1 so that port 0 wins the first tie.
    assign w_winner = (req0 && req1) ? ~r_last : req1;

    assign w_req_granted = r_grant ? req1 : req0;

    assign w_rd_value = (r_addr == 5'd0) ? '0 : r_regs[r_addr];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_SERVE;
                end
            end
            S_SERVE: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (!w_req_granted) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latch, register file, read data and acknowledge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= 5'd0;
            r_wdata  <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The command is captured here and held for the whole
                    // transaction, so later input changes have no effect.
                    if (w_any_req) begin
                        r_grant <= w_winner;
                        r_we    <= w_winner ? we1    : we0;
                        r_addr  <= w_winner ? addr1  : addr0;
                        r_wdata <= w_winner ? wdata1 : wdata0;
                    end
                end
                S_SERVE: begin
                    if (r_we) begin
                        if (r_addr != 5'd0) begin
                            r_regs[r_addr] <= r_wdata;
                        end
                    end else if (r_grant) begin
                        r_rdata1 <= w_rd_value;
                    end else begin
                        r_rdata0 <= w_rd_value;
                    end
                    r_ack0 <= ~r_grant;
                    r_ack1 <= r_grant;
                end
                S_DONE: begin
                    if (!w_req_granted) begin
                        r_ack0 <= 1'b0;
                        r_ack1 <= 1'b0;
                        r_last <= r_grant;
                    end
                end
                default: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                end
            endcase
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign busy   = (r_state != S_IDLE);
    assign grant  = r_grant;

endmodule
`default_nettype wire
